// File: rtl/fetch_decode_if.sv
// Bundle of instruction-memory, redirect and decoded-output signals for fetch_decode.
// The slave modport is the fetch stage; the master modport is memory/redirect/consumer side.
interface fetch_decode_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  out_fmt;
    logic [20:0] out_imm;
    logic        out_illegal;

    modport slave (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_instr, out_fmt, out_imm, out_illegal,
        input  out_ready
    );

    modport master (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_instr, out_fmt, out_imm, out_illegal,
        output out_ready
    );
endinterface

// File: rtl/fetch_decode.sv
// Instruction fetch with a small response FIFO and immediate-format pre-decode for Imm_Gen.
// Optional feature: define FETCH_DECODE_ILLEGAL_EN to build the unsupported-opcode flag.
module fetch_decode #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_decode_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_C = FIFO_DEPTH[CW:0];
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [31:0]   PC_STEP = 32'd4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Returns {fmt[2:0], imm[20:0]} for one instruction word.
    function automatic logic [23:0] predecode(input logic [31:0] instr);
        logic [2:0]  fmt;
        logic [20:0] imm;
        fmt = 3'b000;
        imm = 21'd0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                fmt = 3'b001;
                imm = {9'b0, instr[31:20]};
            end
            OPC_STORE: begin
                fmt = 3'b001;
                imm = {9'b0, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt = 3'b011;
                imm = {9'b0, instr[31], instr[7], instr[30:25], instr[11:8]};
            end
            OPC_JAL: begin
                fmt = 3'b011;
                imm = {1'b0, instr[31], instr[19:12], instr[20], instr[30:21]};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = 3'b100;
                imm = {1'b0, instr[31:12]};
            end
            OPC_OP: begin
                fmt = 3'b000;
                imm = 21'd0;
            end
            default: begin
                fmt = 3'b000;
                imm = 21'd0;
            end
        endcase
        return {fmt, imm};
    endfunction

`ifdef FETCH_DECODE_ILLEGAL_EN
    function automatic logic is_illegal(input logic [31:0] instr);
        logic known;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_OP: known = 1'b1;
            default:                             known = 1'b0;
        endcase
        return !known || (instr[1:0] != 2'b11);
    endfunction
`endif

    logic [31:0]   pc_r;
    logic [31:0]   rsp_pc_r;
    logic [CW-1:0] outst_r;
    logic [CW-1:0] drop_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outst_nxt_s;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [31:0]   fifo_pc_r    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_r [FIFO_DEPTH];

    logic          credit_s;
    logic          req_s;
    logic          fire_s;
    logic          rsp_s;
    logic          push_s;
    logic          pop_s;
    logic          out_valid_s;
    logic [31:0]   head_pc_s;
    logic [31:0]   head_instr_s;
    logic [23:0]   dec_s;

    // A pop in the same cycle is deliberately not credited, so credit only uses registered state.
    assign credit_s    = ({1'b0, count_r} + {1'b0, outst_r}) < DEPTH_C;
    assign req_s       = rst_n && !bus.redirect_valid && credit_s;
    assign fire_s      = req_s && bus.imem_gnt;
    assign rsp_s       = bus.imem_rvalid && (outst_r != CNT_ZERO);
    assign push_s      = rsp_s && (drop_r == CNT_ZERO) && !bus.redirect_valid;
    assign out_valid_s = (count_r != CNT_ZERO);
    assign pop_s       = out_valid_s && bus.out_ready && !bus.redirect_valid;

    // Outstanding-request count as it will stand after this edge.
    always_comb begin
        outst_nxt_s = outst_r;
        if (fire_s && !rsp_s) begin
            outst_nxt_s = outst_r + CNT_ONE;
        end else if (!fire_s && rsp_s) begin
            outst_nxt_s = outst_r - CNT_ONE;
        end else begin
            outst_nxt_s = outst_r;
        end
    end

    // Fetch PC, response PC, in-flight and drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r     <= RESET_PC;
            rsp_pc_r <= RESET_PC;
            outst_r  <= CNT_ZERO;
            drop_r   <= CNT_ZERO;
        end else if (bus.redirect_valid) begin
            pc_r     <= bus.redirect_pc;
            rsp_pc_r <= bus.redirect_pc;
            outst_r  <= outst_nxt_s;
            drop_r   <= outst_nxt_s;
        end else begin
            outst_r <= outst_nxt_s;
            if (fire_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            if (push_s) begin
                rsp_pc_r <= rsp_pc_r + PC_STEP;
            end
            if (rsp_s && (drop_r != CNT_ZERO)) begin
                drop_r <= drop_r - CNT_ONE;
            end
        end
    end

    // Instruction buffer; storage is cleared on reset so idle outputs read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_r[i]    <= 32'd0;
                fifo_instr_r[i] <= 32'd0;
            end
        end else if (bus.redirect_valid) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]    <= rsp_pc_r;
                fifo_instr_r[wr_ptr_r] <= bus.imem_rdata;
                wr_ptr_r               <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_pc_s    = fifo_pc_r[rd_ptr_r];
    assign head_instr_s = fifo_instr_r[rd_ptr_r];
    assign dec_s        = predecode(head_instr_s);

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = pc_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_pc    = head_pc_s;
    assign bus.out_instr = head_instr_s;
    assign bus.out_fmt   = dec_s[23:21];
    assign bus.out_imm   = dec_s[20:0];

`ifdef FETCH_DECODE_ILLEGAL_EN
    assign bus.out_illegal = out_valid_s && is_illegal(head_instr_s);
`else
    assign bus.out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: decode vector table, stall/redirect sequences and
// randomized traffic against a queue-based reference model with an in-order memory model.
module tb_fetch_decode;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;

    fetch_decode_if bus();

    fetch_decode #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct { logic [31:0] instr; logic [2:0] fmt; logic [20:0] imm; logic ill; } vec_t;

    localparam logic [6:0] OPCS [10] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                                          7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
                                          7'b0110011, 7'b0001111};

    pend_t       pend_q[$];
    ent_t        exp_q[$];
    logic [31:0] data_q[$];
    logic [31:0] fire_log[$];
    logic [31:0] mdl_pc;
    int          mdl_drop;
    int          cyc;
    int          lat_min, lat_max;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decode written from the field rules with shifts and masks; returns {fmt, imm}.
    function automatic logic [23:0] ref_dec(input logic [31:0] w);
        int unsigned u, opc;
        logic [31:0] fv, iv;
        u   = w;
        opc = u & 127;
        fv  = 0;
        iv  = 0;
        if (opc == 3 || opc == 19 || opc == 103) begin
            fv = 1; iv = u >> 20;
        end else if (opc == 35) begin
            fv = 1; iv = ((u >> 25) << 5) | ((u >> 7) & 31);
        end else if (opc == 99) begin
            fv = 3; iv = ((u >> 31) << 11) | (((u >> 7) & 1) << 10) | (((u >> 25) & 63) << 4) | ((u >> 8) & 15);
        end else if (opc == 111) begin
            fv = 3; iv = ((u >> 31) << 19) | (((u >> 12) & 255) << 11) | (((u >> 20) & 1) << 10) | ((u >> 21) & 1023);
        end else if (opc == 55 || opc == 23) begin
            fv = 4; iv = u >> 12;
        end
        return {fv[2:0], iv[20:0]};
    endfunction

    function automatic logic ref_ill(input logic [31:0] w);
`ifdef FETCH_DECODE_ILLEGAL_EN
        int unsigned opc;
        opc = w & 127;
        if ((w & 3) != 3) return 1'b1;
        return !(opc == 3 || opc == 19 || opc == 103 || opc == 35 || opc == 99 ||
                 opc == 111 || opc == 55 || opc == 23 || opc == 51);
`else
        return (w === 32'hxxxx_xxxx);
`endif
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom();
        k = $urandom_range(10, 0);
        if (k < 10) w[6:0] = OPCS[k];
        return w;
    endfunction

    task automatic check_reset();
        chk("rst_imem_req",    32'(bus.imem_req),    32'd0);
        chk("rst_imem_addr",   bus.imem_addr,        RST_PC);
        chk("rst_out_valid",   32'(bus.out_valid),   32'd0);
        chk("rst_out_pc",      bus.out_pc,           32'd0);
        chk("rst_out_instr",   bus.out_instr,        32'd0);
        chk("rst_out_fmt",     32'(bus.out_fmt),     32'd0);
        chk("rst_out_imm",     32'(bus.out_imm),     32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        rst_n              = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.out_ready      = 1'b0;
        #1;
        check_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset();
        pend_q.delete();
        exp_q.delete();
        data_q.delete();
        fire_log.delete();
        mdl_pc   = RST_PC;
        mdl_drop = 0;
        cyc      = 0;
        rst_n    = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model and DUT.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, input int gnt_pct);
        logic        rv, g, exp_req, fire, pop;
        logic [23:0] d;
        pend_t       p;
        ent_t        e;
        rv = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
        g  = ($urandom_range(99, 0) < gnt_pct);
        bus.imem_gnt       = g;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = $urandom();
        if (rv) bus.imem_rdata = pend_q[0].data;
        bus.out_ready      = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
        exp_req = !redir && ((exp_q.size() + pend_q.size()) < DEPTH);
        chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", bus.imem_addr, mdl_pc);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            d = ref_dec(exp_q[0].instr);
            chk("out_pc",      bus.out_pc,           exp_q[0].pc);
            chk("out_instr",   bus.out_instr,        exp_q[0].instr);
            chk("out_fmt",     32'(bus.out_fmt),     32'(d[23:21]));
            chk("out_imm",     32'(bus.out_imm),     32'(d[20:0]));
            chk("out_illegal", 32'(bus.out_illegal), 32'(ref_ill(exp_q[0].instr)));
        end
        fire = bus.imem_req && g;
        pop  = (exp_q.size() != 0) && rdy && !redir;
        if (pop) e = exp_q.pop_front();
        if (rv) begin
            p = pend_q.pop_front();
            if (!redir) begin
                if (mdl_drop > 0) mdl_drop--;
                else exp_q.push_back('{pc: p.addr, instr: p.data});
            end
        end
        if (fire) begin
            p.addr = bus.imem_addr;
            p.data = (data_q.size() != 0) ? data_q.pop_front() : rand_instr();
            p.due  = cyc + 1 + $urandom_range(lat_max, lat_min);
            pend_q.push_back(p);
            fire_log.push_back(bus.imem_addr);
            mdl_pc = mdl_pc + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            mdl_drop = pend_q.size();
            mdl_pc   = rpc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[12];
        int          k, first_v, found;
        logic        exp_ill;
        logic [31:0] hold_instr;

        vt[0]  = '{32'hFFF00093, 3'b001, 21'h000FFF, 1'b0};
        vt[1]  = '{32'h123450B7, 3'b100, 21'h012345, 1'b0};
        vt[2]  = '{32'h0080006F, 3'b011, 21'h000004, 1'b0};
        vt[3]  = '{32'hFE000EE3, 3'b011, 21'h000FFE, 1'b0};
        vt[4]  = '{32'h00112623, 3'b001, 21'h00000C, 1'b0};
        vt[5]  = '{32'h00412083, 3'b001, 21'h000004, 1'b0};
        vt[6]  = '{32'hABCDE117, 3'b100, 21'h0ABCDE, 1'b0};
        vt[7]  = '{32'h800080E7, 3'b001, 21'h000800, 1'b0};
        vt[8]  = '{32'h002081B3, 3'b000, 21'h000000, 1'b0};
        vt[9]  = '{32'h00000000, 3'b000, 21'h000000, 1'b1};
        vt[10] = '{32'hFFFFFFFF, 3'b000, 21'h000000, 1'b1};
        vt[11] = '{32'hFFDFF0EF, 3'b011, 21'h0FFFFE, 1'b0};

        rst_n = 1'b0;
        lat_min = 0;
        lat_max = 0;
        @(negedge clk);

        // Decode table through the fetch path, gnt always, single-cycle memory.
        do_reset();
        foreach (vt[i]) data_q.push_back(vt[i].instr);
        k = 0;
        first_v = -1;
        for (int t = 0; t < 100 && k < 12; t++) begin
            step(1'b1, 1'b0, 32'd0, 100);
            if (bus.out_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    chk("first_valid_cycle", 32'(first_v), 32'd2);
                end
                exp_ill = vt[k].ill;
`ifndef FETCH_DECODE_ILLEGAL_EN
                exp_ill = 1'b0;
`endif
                chk("tbl_pc",      bus.out_pc,            RST_PC + 32'(4 * k));
                chk("tbl_fmt",     32'(bus.out_fmt),      32'(vt[k].fmt));
                chk("tbl_imm",     32'(bus.out_imm),      32'(vt[k].imm));
                chk("tbl_illegal", 32'(bus.out_illegal),  32'(exp_ill));
                k++;
            end
        end
        chk("tbl_count", 32'(k), 32'd12);
        chk("addr_seq0", (fire_log.size() > 0) ? fire_log[0] : 32'hDEAD_BEEF, 32'h0);
        chk("addr_seq1", (fire_log.size() > 1) ? fire_log[1] : 32'hDEAD_BEEF, 32'h4);
        chk("addr_seq2", (fire_log.size() > 2) ? fire_log[2] : 32'hDEAD_BEEF, 32'h8);

        // Downstream stalled for ten cycles: buffer fills, head holds, fetch resumes after pop.
        do_reset();
        hold_instr = 32'd0;
        for (int t = 0; t < 10; t++) begin
            step(1'b0, 1'b0, 32'd0, 100);
            if (t == 2) hold_instr = bus.out_instr;
        end
        chk("stall_grants",     32'(fire_log.size()), 32'(DEPTH));
        chk("stall_head_valid", 32'(bus.out_valid),   32'd1);
        chk("stall_head_pc",    bus.out_pc,           RST_PC);
        chk("stall_head_instr", bus.out_instr,        hold_instr);
        chk("stall_req_low",    32'(bus.imem_req),    32'd0);
        step(1'b1, 1'b0, 32'd0, 100);
        chk("req_after_pop",    32'(bus.imem_req),    32'd1);

        // Redirect with two responses in flight.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        step(1'b1, 1'b0, 32'd0, 100);
        step(1'b1, 1'b0, 32'd0, 100);
        chk("two_in_flight_req", 32'(bus.imem_req), 32'd0);
        step(1'b1, 1'b1, 32'h0000_0100, 100);
        chk("redir_valid_low", 32'(bus.out_valid), 32'd0);
        found = 0;
        for (int t = 0; t < 40 && found == 0; t++) begin
            step(1'b1, 1'b0, 32'd0, 100);
            if (bus.out_valid) begin
                found = 1;
                chk("redir_first_pc", bus.out_pc, 32'h0000_0100);
            end
        end
        chk("redir_refetch_seen", 32'(found), 32'd1);

        // Randomized traffic: variable grant, latency, backpressure and redirects.
        do_reset();
        lat_min = 0;
        lat_max = 3;
        for (int t = 0; t < 3000; t++) begin
            step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 4,
                 $urandom() & 32'h0000_FFFC, 60);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
